// File: rtl/mac_accumulator.sv
// Streaming signed fixed-point multiply-accumulate: KLEN products per window, summed at full
// precision, rescaled by Q, saturated to N bits and presented on a valid/ready output.
module mac_accumulator #(
    parameter int unsigned N     = 16,
    parameter int unsigned Q     = 12,
    parameter int unsigned KLEN  = 9,
    parameter int unsigned ACC_W = 2*N+4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    input  logic [N-1:0] weight,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dout,
    output logic         sat
);

    localparam int unsigned PW    = 2*N;
    localparam int unsigned CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;

    // Saturation bounds of the N-bit output, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic                    en;
    logic                    p_valid_q, p_valid_d;
    logic signed [PW-1:0]    p_q, p_d;
    logic                    p_last_q, p_last_d;
    logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [N-1:0]            dout_q, dout_d;
    logic                    sat_q, sat_d;

    logic signed [PW-1:0]    din_x, wt_x;
    logic signed [ACC_W-1:0] sum, r;
    logic                    last_tap;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign sat       = sat_q;

    always_comb begin
        p_valid_d   = p_valid_q;
        p_d         = p_q;
        p_last_d    = p_last_q;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        sat_d       = sat_q;

        din_x    = PW'($signed(din));
        wt_x     = PW'($signed(weight));
        last_tap = (tap_cnt_q == CNT_W'(KLEN-1));
        sum      = acc_q + ACC_W'(p_q);
        r        = sum >>> Q;

        if (en) begin
            // Stage 1: capture the product of the accepted pair.
            p_valid_d = in_valid;
            if (in_valid) begin
                p_d       = din_x * wt_x;
                p_last_d  = last_tap;
                tap_cnt_d = last_tap ? '0 : tap_cnt_q + CNT_W'(1);
            end

            // Stage 2: en implies any pending result is consumed this cycle.
            out_valid_d = 1'b0;
            if (p_valid_q) begin
                if (!p_last_q) begin
                    acc_d = sum;
                end else begin
                    acc_d       = '0;
                    out_valid_d = 1'b1;
                    if (r > MAX_V) begin
                        dout_d = MAX_V[N-1:0];
                        sat_d  = 1'b1;
                    end else if (r < MIN_V) begin
                        dout_d = MIN_V[N-1:0];
                        sat_d  = 1'b1;
                    end else begin
                        dout_d = r[N-1:0];
                        sat_d  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q   <= 1'b0;
            p_q         <= '0;
            p_last_q    <= 1'b0;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else begin
            p_valid_q   <= p_valid_d;
            p_q         <= p_d;
            p_last_q    <= p_last_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed windows from the plan plus randomized streams with gaps and
// backpressure, scored against a window-sum reference model.
module tb_mac_accumulator;

    localparam int unsigned N    = 16;
    localparam int unsigned Q    = 12;
    localparam int unsigned KLEN = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  din = '0;
    logic [N-1:0]  weight = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  dout;
    logic          sat;

    int vectors = 0;
    int miscompares = 0;
    int results_seen = 0;

    // Reference model state: running window sum and queue of expected {sat, dout}.
    longint      m_sum = 0;
    int          m_cnt = 0;
    logic [N:0]  exp_q[$];

    mac_accumulator #(.N(N), .Q(Q), .KLEN(KLEN), .ACC_W(2*N+4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .weight(weight),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] window_result(input longint s);
        longint r;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (N-1)) - 1;
        minv = -(longint'(1) <<< (N-1));
        r = s >>> Q;
        if (r > maxv) return {1'b1, N'(maxv)};
        if (r < minv) return {1'b1, N'(minv)};
        return {1'b0, N'(r)};
    endfunction

    // Inputs change at posedge+1; the monitor samples mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                logic [N:0] e;
                vectors++;
                results_seen++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL result_unexpected: got dout=%h sat=%b, required no output", dout, sat);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, dout} !== e) begin
                        miscompares++;
                        $display("FAIL result_model: got dout=%h sat=%b, required dout=%h sat=%b",
                                 dout, sat, e[N-1:0], e[N]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_sum += longint'($signed(din)) * longint'($signed(weight));
                m_cnt++;
                if (m_cnt == KLEN) begin
                    exp_q.push_back(window_result(m_sum));
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic drive_pair(input logic [N-1:0] d, input logic [N-1:0] w);
        in_valid = 1'b1;
        din      = d;
        weight   = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required acceptance");
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (dout !== '0) begin miscompares++; $display("FAIL reset_dout: got %h, required 0000", dout); end
        if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b, required 0", sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_window(input logic [N-1:0] d, input logic [N-1:0] w,
                               input logic [N-1:0] exp_d, input logic exp_s, input string name);
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < KLEN; i++) drive_pair(d, w);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        vectors += 3;
        if (n !== 2 || !out_valid) begin
            miscompares++;
            $display("FAIL %s_latency: got out_valid=%b after %0d cycles, required 1 after 2", name, out_valid, n);
        end
        if (dout !== exp_d) begin
            miscompares++;
            $display("FAIL %s_dout: got %h, required %h", name, dout, exp_d);
        end
        if (sat !== exp_s) begin
            miscompares++;
            $display("FAIL %s_sat: got %b, required %b", name, sat, exp_s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] held;
        int start_seen;
        start_seen = results_seen;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 2*KLEN; i++)
                    drive_pair(N'($urandom_range(0, 16'hFFFF)), N'($urandom_range(0, 16'h3FFF)));
            end
            begin
                int k;
                k = 0;
                while (!out_valid && k < 100) begin @(negedge clk); k++; end
                held = dout;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    vectors += 2;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
                    end
                    if (dout !== held) begin
                        miscompares++;
                        $display("FAIL stall_dout: got %h, required %h", dout, held);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (results_seen - start_seen !== 2) begin
            miscompares++;
            $display("FAIL stall_count: got %0d results, required 2", results_seen - start_seen);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            drive_pair(N'($urandom_range(0, 16'hFFFF)), N'($urandom_range(0, 16'hFFFF)));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        test_window(16'h0800, 16'h0800, 16'h2400, 1'b0, "midrst_fresh");
    endtask

    task automatic test_random();
        bit done;
        int k;
        done = 1'b0;
        fork
            begin
                for (int wdw = 0; wdw < 12; wdw++)
                    for (int t = 0; t < KLEN; t++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #0;
                        drive_pair(N'($urandom), N'($urandom));
                    end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || m_cnt != 0) begin
            miscompares++;
            $display("FAIL random_drain: got %0d pending results, %0d partial taps, required 0/0", exp_q.size(), m_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_window(16'h0800, 16'h0800, 16'h2400, 1'b0, "pos_sum");
        test_window(16'hF000, 16'h0800, 16'hB800, 1'b0, "neg_sum");
        test_window(16'h1000, 16'h1000, 16'h7FFF, 1'b1, "pos_sat");
        test_window(16'hF000, 16'h1000, 16'h8000, 1'b1, "neg_sat");
        test_window(16'h0001, 16'h0001, 16'h0000, 1'b0, "trunc_pos");
        test_window(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, "trunc_neg");
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
